axi4_sram_slave: RTL and testbench
==================================

# axi4_sram_slave

AXI4 slave memory that terminates the downstream side of the AXI4 delay stage: it consumes the `out_*` channel set that the delay stage forwards and returns R/B responses for the delay stage to time-stretch. It serves single and burst reads and writes from an internal word array, with a programmable read-access latency. Together with the delay stage it forms a self-contained simulated memory for SoC bring-up.

## Interface
Parameters:
- `BASE`, 32'h8000_0000, byte address of word 0.
- `DEPTH`, 1024, number of 32-bit words (power of two, ≥ 16).
- `RD_LATENCY`, 2, idle cycles between the AR handshake and the first R beat (0–15).

Ports:
- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `in_arready` out 1; `in_arvalid` in 1; `in_arid` in 4; `in_araddr` in 32; `in_arlen` in 8; `in_arsize` in 3; `in_arburst` in 2.
- `in_rready` in 1; `in_rvalid` out 1; `in_rid` out 4; `in_rdata` out 32; `in_rresp` out 2; `in_rlast` out 1.
- `in_awready` out 1; `in_awvalid` in 1; `in_awid` in 4; `in_awaddr` in 32; `in_awlen` in 8; `in_awsize` in 3; `in_awburst` in 2.
- `in_wready` out 1; `in_wvalid` in 1; `in_wdata` in 32; `in_wstrb` in 4; `in_wlast` in 1.
- `in_bready` in 1; `in_bvalid` out 1; `in_bid` out 4; `in_bresp` out 2.

## Operation
- Read FSM:
  - `R_IDLE` (arready=1). AR handshake latches id, addr, len, size, and burst, then goes to `R_WAIT` (or to `R_DATA` when RD_LATENCY=0).
  - `R_WAIT` counts RD_LATENCY cycles, then goes to `R_DATA`.
  - `R_DATA` drives rvalid=1 with the current beat.
    - On an R handshake, advance the address and the beat count.
    - On the handshake with rlast=1, return to `R_IDLE`.
- Write FSM:
  - `W_IDLE` (awready=1). AW handshake latches the AW fields and goes to `W_DATA`.
  - `W_DATA` (wready=1). Each W handshake writes the bytes enabled by wstrb.
    - The burst ends on the beat with wlast=1 or the beat where count==awlen, whichever comes first.
    - At burst end, go to `W_RESP`.
  - `W_RESP` drives bvalid=1. On a B handshake, return to `W_IDLE`.
- W beats are not accepted before AW: wready=0 outside `W_DATA`.
- Addressing:
  - Word index = (addr − BASE)>>2, taken modulo DEPTH after the range check.
  - INCR: addr += 1<<size per beat.
  - FIXED: addr is held for all beats.
  - WRAP (2'b10) and reserved (2'b11) burst types are served as INCR and flagged as an error.
- Read data is always the full aligned word; narrow writes rely on wstrb only.
- rlast=1 exactly on beat `arlen`. rid and bid equal the latched ids.
- Response rules:
  - Resp is OKAY (2'b00) unless one of the conditions below applies.
  - SLVERR (2'b10) is returned per beat for reads when any of these hold: the beat address is outside [BASE, BASE+4·DEPTH); size>2; the burst is WRAP or reserved. An erroring read beat returns rdata=0.
  - SLVERR (2'b10) is returned as bresp for a write burst when any write beat hits an error condition, or when the wlast position does not match awlen. Erroring write beats are dropped, with no memory write.
- The read and write FSMs are fully independent.
  - If a read and a write hit the same word in the same cycle, the read returns the old data.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - rvalid=0, rlast=0, rid=0, rdata=0, rresp=0.
  - bvalid=0, bid=0, bresp=0.
  - arready=1, awready=1, wready=0; both FSMs in IDLE.
- A reset asserted mid-burst aborts the burst immediately. No partial B is issued; beats already written remain in memory.
- If AR handshakes at cycle T, the first rvalid is at T+1+RD_LATENCY.
- Beats are back-to-back while rready=1.
- The R outputs are registered and stay stable while rvalid=1 and rready=0.
- After the last R handshake at cycle T, arready=1 at T+1.
- With RD_LATENCY=0, the minimum read cost is 2 cycles per single-beat transaction.
- wready=1 from the cycle after the AW handshake.
- bvalid=1 the cycle after the final W handshake and is held until bready.
- awready returns to 1 the cycle after the B handshake.
- The 256-beat maximum (arlen=255) must be supported; the beat counter is 8 bits and must not wrap early.
- The latency counter is 4 bits.

## Structure
- Package `axi4_pkg`:
  - `RESP_OKAY`, `RESP_SLVERR`, `RESP_DECERR`.
  - `BURST_FIXED`, `BURST_INCR`, `BURST_WRAP`.
  - `rd_state_t` {R_IDLE, R_WAIT, R_DATA}.
  - `wr_state_t` {W_IDLE, W_DATA, W_RESP}.
- Sub-module `axi4_burst_addr` is combinational: (addr, size, burst) → (next_addr, beat_err). It is instantiated once in the read path and once in the write path.
- Memory is a `reg [31:0] mem[0:DEPTH-1]` with four byte-lane write enables.

## Test plan
- Single write then read:
  - AW addr=BASE+8, len=0, size=2, wdata=32'hDEADBEEF, wstrb=4'hF, then AR same address, len=0.
  - Expect bresp=0, rdata=32'hDEADBEEF, rlast=1, rvalid exactly 3 cycles after the AR handshake (RD_LATENCY=2).
- INCR burst of 8:
  - Write 8 words 1..8 at BASE, len=7, then read back with rready toggling every other cycle.
  - Expect data 1..8 in order, rlast only on beat 8, data stable while stalled.
- Byte strobes:
  - Write 32'h11223344 (wstrb=F), then 32'hAABBCCDD with wstrb=4'b0101.
  - Read back 32'h11BB33DD.
- Errors:
  - AR at BASE+4·DEPTH: rresp=2'b10, rdata=0.
  - AW len=3 with wlast on beat 2: bresp=2'b10.
  - AR with size=3: rresp=2'b10.
- Concurrency and reset:
  - Read and write the same word in the same cycle: read returns the old value.
  - Assert reset during beat 3 of a 4-beat read: rvalid=0 and arready=1 on the next cycle; a subsequent read is served normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 encodings and FSM state types for the SRAM slave.
//   RESP_*  : xRESP encodings
//   BURST_* : AxBURST encodings
//   rd_state_t / wr_state_t : read and write FSM states
//   beat_bytes() : bytes per beat for an AxSIZE value
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  function automatic logic [31:0] beat_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// axi4_burst_addr: combinational per-beat address step and error check.
//   addr      in  32  address of the current beat
//   size      in  3   AxSIZE
//   burst     in  2   AxBURST
//   next_addr out 32  address of the following beat
//   beat_err  out 1   beat is out of [BASE, BASE+4*DEPTH), size>2, or WRAP/reserved
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        beat_err
);

  // 33-bit limit so a BASE near the top of the address map cannot overflow.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

  always_comb begin
    // WRAP and reserved bursts advance like INCR; they are flagged below.
    next_addr = (burst == BURST_FIXED) ? addr : addr + beat_bytes(size);
    beat_err  = ({1'b0, addr} < {1'b0, BASE}) ||
                ({1'b0, addr} >= LIMIT)       ||
                (size > 3'd2)                 ||
                burst[1];
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave backed by a DEPTH x 32-bit word array.
//   clock, reset         : sole clock, synchronous active-high reset
//   in_ar* / in_r*       : read address / read data channels
//   in_aw* / in_w* / in_b* : write address / write data / write response channels
//   rd_state_dbg, wr_state_dbg : current read / write FSM states
// Reads wait RD_LATENCY idle cycles after AR before the first R beat.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. This slave never withdraws a valid it has raised and holds its
// payload stable until the matching ready is seen.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH      = 1024,
  parameter int          RD_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_arready,
  input  logic        in_arvalid,
  input  logic [3:0]  in_arid,
  input  logic [31:0] in_araddr,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  input  logic        in_rready,
  output logic        in_rvalid,
  output logic [3:0]  in_rid,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  output logic        in_awready,
  input  logic        in_awvalid,
  input  logic [3:0]  in_awid,
  input  logic [31:0] in_awaddr,
  input  logic [7:0]  in_awlen,
  input  logic [2:0]  in_awsize,
  input  logic [1:0]  in_awburst,
  output logic        in_wready,
  input  logic        in_wvalid,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wlast,
  input  logic        in_bready,
  output logic        in_bvalid,
  output logic [3:0]  in_bid,
  output logic [1:0]  in_bresp,
  output rd_state_t   rd_state_dbg,
  output wr_state_t   wr_state_dbg
);

  localparam int AW = $clog2(DEPTH);

  // Word index, taken modulo DEPTH; out-of-range beats never reach the array.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  reg [31:0] mem [0:DEPTH-1];

  // ---------------------------------------------------------------- read path
  rd_state_t   rd_state, rd_state_nxt;
  logic [3:0]  rd_id;
  logic [31:0] rd_addr;   // address of the next beat to fetch
  logic [7:0]  rd_len, rd_cnt;
  logic [2:0]  rd_size;
  logic [1:0]  rd_burst;
  logic [3:0]  lat_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic        ar_hs, r_hs, lat_done, rd_load;
  logic [31:0] fa_addr, fa_next;
  logic [2:0]  fa_size;
  logic [1:0]  fa_burst;
  logic [7:0]  fa_cnt, fa_len;
  logic        fa_err;

  assign ar_hs    = in_arvalid && in_arready;
  assign r_hs     = in_rvalid && in_rready;
  assign lat_done = (rd_state == R_WAIT) && (lat_cnt == 4'(RD_LATENCY - 1));

  // Selects which beat is fetched into the R output registers this cycle:
  // straight from AR when there is no latency, otherwise from rd_addr.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_load      = 1'b0;
    fa_addr      = rd_addr;
    fa_size      = rd_size;
    fa_burst     = rd_burst;
    fa_len       = rd_len;
    fa_cnt       = rd_cnt + 8'd1;
    case (rd_state)
      R_IDLE: begin
        fa_addr  = in_araddr;
        fa_size  = in_arsize;
        fa_burst = in_arburst;
        fa_len   = in_arlen;
        fa_cnt   = 8'd0;
        if (ar_hs) begin
          if (RD_LATENCY == 0) begin
            rd_state_nxt = R_DATA;
            rd_load      = 1'b1;
          end else begin
            rd_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        fa_cnt = 8'd0;
        if (lat_done) begin
          rd_state_nxt = R_DATA;
          rd_load      = 1'b1;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q) rd_state_nxt = R_IDLE;
          else         rd_load      = 1'b1;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  axi4_burst_addr #(.BASE(BASE), .DEPTH(DEPTH)) u_rd_addr (
    .addr      (fa_addr),
    .size      (fa_size),
    .burst     (fa_burst),
    .next_addr (fa_next),
    .beat_err  (fa_err)
  );

  always_ff @(posedge clock) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_id    <= '0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_cnt   <= '0;
      lat_cnt  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        rd_id    <= in_arid;
        rd_addr  <= in_araddr;
        rd_len   <= in_arlen;
        rd_size  <= in_arsize;
        rd_burst <= in_arburst;
        rd_cnt   <= '0;
        lat_cnt  <= '0;
      end
      if (rd_state == R_WAIT) lat_cnt <= lat_cnt + 4'd1;
      if (r_hs)               rd_cnt  <= rd_cnt + 8'd1;
      // The array read is registered, so a write to the same word on the
      // same edge is not visible: the beat carries the old data.
      if (rd_load) begin
        rd_addr <= fa_next;
        rdata_q <= fa_err ? 32'd0 : mem[word_idx(fa_addr)];
        rresp_q <= fa_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q <= (fa_cnt == fa_len);
      end
    end
  end

  assign in_arready = (rd_state == R_IDLE);
  assign in_rvalid  = (rd_state == R_DATA);
  assign in_rid     = rd_id;
  assign in_rdata   = rdata_q;
  assign in_rresp   = rresp_q;
  assign in_rlast   = rlast_q;

  // --------------------------------------------------------------- write path
  wr_state_t   wr_state, wr_state_nxt;
  logic [3:0]  wr_id;
  logic [31:0] wr_addr, wr_next;
  logic [7:0]  wr_len, wr_cnt;
  logic [2:0]  wr_size;
  logic [1:0]  wr_burst;
  logic        wr_err;
  logic [1:0]  bresp_q;

  logic aw_hs, w_hs, b_hs, at_len, w_end, w_bad, wr_beat_err, wr_we;

  assign aw_hs  = in_awvalid && in_awready;
  assign w_hs   = in_wvalid && in_wready;
  assign b_hs   = in_bvalid && in_bready;
  assign at_len = (wr_cnt == wr_len);
  // Burst closes on wlast or on beat awlen, whichever comes first.
  assign w_end  = w_hs && (in_wlast || at_len);
  // A beat is bad if its address/size/burst errs or wlast disagrees with awlen.
  assign w_bad  = wr_beat_err || (in_wlast != at_len);
  assign wr_we  = w_hs && !wr_beat_err && !reset;

  axi4_burst_addr #(.BASE(BASE), .DEPTH(DEPTH)) u_wr_addr (
    .addr      (wr_addr),
    .size      (wr_size),
    .burst     (wr_burst),
    .next_addr (wr_next),
    .beat_err  (wr_beat_err)
  );

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_state_nxt = W_DATA;
      W_DATA:  if (w_end) wr_state_nxt = W_RESP;
      W_RESP:  if (b_hs)  wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
      bresp_q  <= '0;
    end else begin
      if (aw_hs) begin
        wr_id    <= in_awid;
        wr_addr  <= in_awaddr;
        wr_len   <= in_awlen;
        wr_size  <= in_awsize;
        wr_burst <= in_awburst;
        wr_cnt   <= '0;
        wr_err   <= 1'b0;
      end
      if (w_hs) begin
        wr_addr <= wr_next;
        wr_cnt  <= wr_cnt + 8'd1;
        if (w_bad) wr_err <= 1'b1;
        if (w_end) bresp_q <= (wr_err || w_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Array has no reset: contents survive reset by design.
  always_ff @(posedge clock) begin
    if (wr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (in_wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= in_wdata[8*b +: 8];
      end
    end
  end

  assign in_awready = (wr_state == W_IDLE);
  assign in_wready  = (wr_state == W_DATA);
  assign in_bvalid  = (wr_state == W_RESP);
  assign in_bid     = wr_id;
  assign in_bresp   = bresp_q;

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Testbench for axi4_sram_slave: directed scenarios plus randomized traffic,
// checked against a word-array reference model of the slave memory.
module tb_axi4_sram_slave;
  import axi4_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          L     = 2;
  localparam logic [31:0] LIMIT = BASE + 32'(4 * DEPTH);

  logic        clock, reset;
  logic        in_arready, in_arvalid;
  logic [3:0]  in_arid;
  logic [31:0] in_araddr;
  logic [7:0]  in_arlen;
  logic [2:0]  in_arsize;
  logic [1:0]  in_arburst;
  logic        in_rready, in_rvalid;
  logic [3:0]  in_rid;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_rlast;
  logic        in_awready, in_awvalid;
  logic [3:0]  in_awid;
  logic [31:0] in_awaddr;
  logic [7:0]  in_awlen;
  logic [2:0]  in_awsize;
  logic [1:0]  in_awburst;
  logic        in_wready, in_wvalid;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        in_wlast;
  logic        in_bready, in_bvalid;
  logic [3:0]  in_bid;
  logic [1:0]  in_bresp;
  rd_state_t   rd_state_dbg;
  wr_state_t   wr_state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];

  axi4_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .RD_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .in_arready(in_arready), .in_arvalid(in_arvalid), .in_arid(in_arid),
    .in_araddr(in_araddr), .in_arlen(in_arlen), .in_arsize(in_arsize),
    .in_arburst(in_arburst),
    .in_rready(in_rready), .in_rvalid(in_rvalid), .in_rid(in_rid),
    .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rlast(in_rlast),
    .in_awready(in_awready), .in_awvalid(in_awvalid), .in_awid(in_awid),
    .in_awaddr(in_awaddr), .in_awlen(in_awlen), .in_awsize(in_awsize),
    .in_awburst(in_awburst),
    .in_wready(in_wready), .in_wvalid(in_wvalid), .in_wdata(in_wdata),
    .in_wstrb(in_wstrb), .in_wlast(in_wlast),
    .in_bready(in_bready), .in_bvalid(in_bvalid), .in_bid(in_bid),
    .in_bresp(in_bresp),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  // ---------------------------------------------------- clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------- reference model
  function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return (a < BASE) || (a >= LIMIT) || (sz > 3'd2) || (bu >= 2'd2);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return (bu == 2'd0) ? a : a + (32'd1 << sz);
  endfunction

  // Apply a write burst to the model; returns the expected bresp.
  function automatic logic [1:0] m_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                                          input logic [1:0] bu, input int nbeats);
    logic [31:0] ad;
    bit e;
    int idx;
    ad = a;
    e = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (m_err(ad, sz, bu)) e = 1;
      else begin
        idx = m_idx(ad);
        for (int b = 0; b < 4; b++)
          if (wbuf_strb[i][b]) ref_mem[idx][8*b +: 8] = wbuf_data[i][8*b +: 8];
      end
      ad = m_next(ad, sz, bu);
    end
    if (nbeats != len + 1) e = 1;
    return e ? 2'b10 : 2'b00;
  endfunction

  function automatic void m_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                                 input logic [1:0] bu);
    logic [31:0] ad;
    ad = a;
    for (int i = 0; i <= len; i++) begin
      if (m_err(ad, sz, bu)) begin
        exp_q.push_back(32'd0);
        exp_resp_q.push_back(2'b10);
      end else begin
        exp_q.push_back(ref_mem[m_idx(ad)]);
        exp_resp_q.push_back(2'b00);
      end
      ad = m_next(ad, sz, bu);
    end
  endfunction

  // ------------------------------------------------------------ driver tasks
  // Every task starts and ends at a falling edge.
  task automatic aw_send(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id);
    int g;
    g = 0;
    in_awvalid = 1'b1; in_awaddr = a; in_awlen = 8'(len);
    in_awsize = sz; in_awburst = bu; in_awid = id;
    while (in_awready !== 1'b1 && g < 100) begin
      @(posedge clock); @(negedge clock); g++;
    end
    if (g >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL aw_timeout: awready=%b required 1", in_awready);
    end
    @(posedge clock); @(negedge clock);
    in_awvalid = 1'b0;
    n_cmp++;
    if (in_wready !== 1'b1) begin
      n_fail++;
      $display("FAIL wready_after_aw: got %b required 1", in_wready);
    end
  endtask

  task automatic w_send(input int nbeats);
    int g;
    for (int i = 0; i < nbeats; i++) begin
      in_wvalid = 1'b1; in_wdata = wbuf_data[i]; in_wstrb = wbuf_strb[i];
      in_wlast = (i == nbeats - 1);
      g = 0;
      while (in_wready !== 1'b1 && g < 100) begin
        @(posedge clock); @(negedge clock); g++;
      end
      if (g >= 100) begin
        n_cmp++; n_fail++;
        $display("FAIL w_timeout: beat %0d wready=%b required 1", i, in_wready);
      end
      @(posedge clock); @(negedge clock);
    end
    in_wvalid = 1'b0; in_wlast = 1'b0;
  endtask

  task automatic b_get(input logic [1:0] exp_resp, input logic [3:0] exp_id, input string name);
    int g;
    logic [1:0] r;
    logic [3:0] bi;
    in_bready = 1'b1;
    g = 0;
    while (in_bvalid !== 1'b1 && g < 100) begin
      @(posedge clock); @(negedge clock); g++;
    end
    if (g >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL %s b_timeout: bvalid=%b required 1", name, in_bvalid);
    end
    r = in_bresp; bi = in_bid;
    @(posedge clock); @(negedge clock);
    in_bready = 1'b0;
    n_cmp++;
    if (r !== exp_resp || bi !== exp_id) begin
      n_fail++;
      $display("FAIL %s bresp/bid: got %b/%h required %b/%h", name, r, bi, exp_resp, exp_id);
    end
    n_cmp++;
    if (in_awready !== 1'b1 || in_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_b: awready=%b bvalid=%b required 1/0", name, in_awready, in_bvalid);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input int nbeats, input logic [3:0] id,
                          input string name);
    logic [1:0] eb;
    eb = m_write(a, len, sz, bu, nbeats);
    aw_send(a, len, sz, bu, id);
    w_send(nbeats);
    n_cmp++;
    if (in_bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s bvalid_timing: got %b required 1 right after last W", name, in_bvalid);
    end
    b_get(eb, id, name);
  endtask

  task automatic ar_send(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id, output int t_ar);
    int g;
    g = 0;
    in_arvalid = 1'b1; in_araddr = a; in_arlen = 8'(len);
    in_arsize = sz; in_arburst = bu; in_arid = id;
    while (in_arready !== 1'b1 && g < 100) begin
      @(posedge clock); @(negedge clock); g++;
    end
    if (g >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL ar_timeout: arready=%b required 1", in_arready);
    end
    t_ar = cyc;
    @(posedge clock); @(negedge clock);
    in_arvalid = 1'b0;
  endtask

  // Takes nb beats from the R channel and scores them against exp_q.
  // mode 0: rready always 1; 1: toggles every cycle; 2: random.
  task automatic r_collect(input int len, input int nb, input int mode, input int t_ar,
                           input logic [3:0] id, input string name);
    int beat, g;
    bit first, stalled;
    logic [31:0] hd, ed;
    logic [1:0] hr, er;
    logic hl;
    beat = 0; g = 0; first = 1; stalled = 0;
    hd = '0; hr = '0; hl = 1'b0;
    while (beat < nb && g < 3000) begin
      if (mode == 0 && !first) begin
        n_cmp++;
        if (in_rvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s back_to_back: beat %0d rvalid=%b required 1", name, beat, in_rvalid);
        end
      end
      if (in_rvalid === 1'b1) begin
        if (first) begin
          first = 0;
          n_cmp++;
          if (cyc - t_ar != 1 + L) begin
            n_fail++;
            $display("FAIL %s latency: first rvalid %0d cycles after AR required %0d",
                     name, cyc - t_ar, 1 + L);
          end
        end
        if (stalled) begin
          stalled = 0;
          n_cmp++;
          if (in_rdata !== hd || in_rresp !== hr || in_rlast !== hl) begin
            n_fail++;
            $display("FAIL %s stall_stable: got %h/%b/%b required %h/%b/%b",
                     name, in_rdata, in_rresp, in_rlast, hd, hr, hl);
          end
        end
        case (mode)
          0:       in_rready = 1'b1;
          1:       in_rready = (cyc % 2 == 0);
          default: in_rready = 1'($urandom_range(0, 1));
        endcase
        if (in_rready) begin
          ed = exp_q.pop_front();
          er = exp_resp_q.pop_front();
          n_cmp++;
          if (in_rdata !== ed || in_rresp !== er || in_rlast !== (beat == len) || in_rid !== id) begin
            n_fail++;
            $display("FAIL %s beat %0d: data/resp/last/id got %h/%b/%b/%h required %h/%b/%b/%h",
                     name, beat, in_rdata, in_rresp, in_rlast, in_rid, ed, er, (beat == len), id);
          end
          beat++;
        end else begin
          stalled = 1;
          hd = in_rdata; hr = in_rresp; hl = in_rlast;
        end
      end
      @(posedge clock); @(negedge clock);
      g++;
    end
    in_rready = 1'b0;
    if (beat < nb) begin
      n_cmp++; n_fail++;
      $display("FAIL %s r_timeout: took %0d beats required %0d", name, beat, nb);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id, input int mode,
                         input string name);
    int t_ar;
    m_read(a, len, sz, bu);
    ar_send(a, len, sz, bu, id, t_ar);
    r_collect(len, len + 1, mode, t_ar, id, name);
    n_cmp++;
    if (in_arready !== 1'b1 || in_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_last_r: arready=%b rvalid=%b required 1/0", name, in_arready, in_rvalid);
    end
  endtask

  // --------------------------------------------------------------- scenarios
  task automatic test_reset();
    reset = 1'b1;
    in_arvalid = 0; in_arid = 0; in_araddr = 0; in_arlen = 0; in_arsize = 0; in_arburst = 0;
    in_rready = 0;
    in_awvalid = 0; in_awid = 0; in_awaddr = 0; in_awlen = 0; in_awsize = 0; in_awburst = 0;
    in_wvalid = 0; in_wdata = 0; in_wstrb = 0; in_wlast = 0; in_bready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({in_rvalid, in_rlast, in_rid, in_rdata, in_rresp, in_bvalid, in_bid, in_bresp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rv=%b rl=%b rid=%h rd=%h rr=%b bv=%b bid=%h br=%b required all 0",
               in_rvalid, in_rlast, in_rid, in_rdata, in_rresp, in_bvalid, in_bid, in_bresp);
    end
    n_cmp++;
    if ({in_arready, in_awready, in_wready} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_ready: ar/aw/w got %b%b%b required 110", in_arready, in_awready, in_wready);
    end
    n_cmp++;
    if (rd_state_dbg !== R_IDLE || wr_state_dbg !== W_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: rd=%0d wr=%0d required R_IDLE/W_IDLE", rd_state_dbg, wr_state_dbg);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Fills the whole array with four 256-beat bursts, then reads 256 beats back.
  task automatic test_max_burst();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wbuf_data[i] = $urandom;
        wbuf_strb[i] = 4'hF;
      end
      do_write(BASE + 32'(k * 1024), 255, 3'd2, BURST_INCR, 256, 4'(k), "fill256");
    end
    do_read(BASE + 32'd512, 255, 3'd2, BURST_INCR, 4'h9, 2, "read256");
  endtask

  task automatic test_single();
    int t_ar;
    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    do_write(BASE + 32'd8, 0, 3'd2, BURST_INCR, 1, 4'h1, "single_wr");
    exp_q.push_back(32'hDEADBEEF);
    exp_resp_q.push_back(2'b00);
    ar_send(BASE + 32'd8, 0, 3'd2, BURST_INCR, 4'h2, t_ar);
    r_collect(0, 1, 0, t_ar, 4'h2, "single_rd");
  endtask

  task automatic test_incr8();
    for (int i = 0; i < 8; i++) begin
      wbuf_data[i] = 32'(i + 1); wbuf_strb[i] = 4'hF;
    end
    do_write(BASE, 7, 3'd2, BURST_INCR, 8, 4'h3, "incr8_wr");
    do_read(BASE, 7, 3'd2, BURST_INCR, 4'h4, 1, "incr8_rd");
  endtask

  task automatic test_strobes();
    int t_ar;
    wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'hF;
    do_write(BASE + 32'h40, 0, 3'd2, BURST_INCR, 1, 4'h5, "strb_wr1");
    wbuf_data[0] = 32'hAABBCCDD; wbuf_strb[0] = 4'b0101;
    do_write(BASE + 32'h40, 0, 3'd2, BURST_INCR, 1, 4'h5, "strb_wr2");
    exp_q.push_back(32'h11BB33DD);
    exp_resp_q.push_back(2'b00);
    ar_send(BASE + 32'h40, 0, 3'd2, BURST_INCR, 4'h6, t_ar);
    r_collect(0, 1, 0, t_ar, 4'h6, "strb_rd");
  endtask

  task automatic test_errors();
    do_read(LIMIT, 0, 3'd2, BURST_INCR, 4'h7, 0, "err_range_rd");
    for (int i = 0; i < 4; i++) begin
      wbuf_data[i] = 32'hC0DE_0000 + 32'(i); wbuf_strb[i] = 4'hF;
    end
    do_write(BASE + 32'h80, 3, 3'd2, BURST_INCR, 3, 4'h8, "err_early_wlast");
    do_read(BASE + 32'h80, 3, 3'd2, BURST_INCR, 4'h8, 0, "err_early_rd");
    do_read(BASE + 32'h80, 0, 3'd3, BURST_INCR, 4'hA, 0, "err_size_rd");
    do_read(BASE + 32'h80, 1, 3'd2, BURST_WRAP, 4'hB, 0, "err_wrap_rd");
    wbuf_data[0] = 32'h5555AAAA; wbuf_strb[0] = 4'hF;
    do_write(LIMIT - 32'd4, 1, 3'd2, BURST_INCR, 2, 4'hC, "err_range_wr");
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 4; i++) begin
      wbuf_data[i] = 32'hF1F0_0000 + 32'(i); wbuf_strb[i] = 4'hF;
    end
    do_write(BASE + 32'h300, 3, 3'd2, BURST_FIXED, 4, 4'hD, "fixed_wr");
    do_read(BASE + 32'h300, 3, 3'd2, BURST_FIXED, 4'hE, 0, "fixed_rd");
  endtask

  // W beat lands on the same edge the read fetches the same word.
  task automatic test_same_cycle();
    int t_ar;
    logic [31:0] x;
    x = BASE + 32'h100;
    wbuf_data[0] = 32'h0BADF00D; wbuf_strb[0] = 4'hF;
    do_write(x, 0, 3'd2, BURST_INCR, 1, 4'h1, "same_pre");
    m_read(x, 0, 3'd2, BURST_INCR);
    aw_send(x, 0, 3'd2, BURST_INCR, 4'h3);
    ar_send(x, 0, 3'd2, BURST_INCR, 4'h5, t_ar);
    repeat (L - 1) @(negedge clock);
    in_wvalid = 1'b1; in_wdata = 32'h600DCAFE; in_wstrb = 4'hF; in_wlast = 1'b1;
    @(posedge clock); @(negedge clock);
    in_wvalid = 1'b0; in_wlast = 1'b0;
    r_collect(0, 1, 0, t_ar, 4'h5, "same_cycle_rd");
    b_get(2'b00, 4'h3, "same_cycle_b");
    ref_mem[m_idx(x)] = 32'h600DCAFE;
    do_read(x, 0, 3'd2, BURST_INCR, 4'h6, 0, "same_after");
  endtask

  task automatic test_reset_mid_read();
    int t_ar;
    m_read(BASE + 32'h200, 3, 3'd2, BURST_INCR);
    ar_send(BASE + 32'h200, 3, 3'd2, BURST_INCR, 4'h7, t_ar);
    r_collect(3, 2, 0, t_ar, 4'h7, "rst_mid_rd");
    n_cmp++;
    if (in_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid beat3_present: rvalid=%b required 1", in_rvalid);
    end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    n_cmp++;
    if (in_rvalid !== 1'b0 || in_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid abort: rvalid=%b arready=%b required 0/1", in_rvalid, in_arready);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_resp_q.delete();
    @(negedge clock);
    do_read(BASE + 32'h200, 3, 3'd2, BURST_INCR, 4'h8, 0, "rst_after_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0] sz;
    logic [1:0] bu;
    int len, nb, r;
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = LIMIT - 32'($urandom_range(0, 8) * 4);
      else if (r == 1) a = BASE - 32'd4;
      else             a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      r = $urandom_range(0, 7);
      sz = (r < 5) ? 3'd2 : (r == 5) ? 3'd0 : (r == 6) ? 3'd1 : 3'd3;
      r = $urandom_range(0, 7);
      bu = (r < 6) ? BURST_INCR : (r == 6) ? BURST_FIXED : 2'($urandom_range(2, 3));
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wbuf_data[i] = $urandom;
          wbuf_strb[i] = 4'($urandom_range(0, 15));
        end
        nb = ($urandom_range(0, 5) == 0 && len > 0) ? $urandom_range(1, len) : len + 1;
        do_write(a, len, sz, bu, nb, 4'($urandom_range(0, 15)), "rand_wr");
      end else begin
        do_read(a, len, sz, bu, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rand_rd");
      end
    end
  endtask

  // ------------------------------------------------------------------ report
  initial begin
    test_reset();
    test_max_burst();
    test_single();
    test_incr8();
    test_strobes();
    test_errors();
    test_fixed();
    test_same_cycle();
    test_reset_mid_read();
    test_random();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
